// File: rtl/frame_bank_sched.sv
// Triple-buffer frame-bank scheduler.
// Shares three frame banks between the camera writer and the HDMI reader.
// W is the bank being written, R is the bank being displayed, and S is the spare.
// A completed frame is parked in S until the next vsync swaps it to the reader.
// The three bank registers always hold a permutation of {0,1,2}, so the writer
// and the reader can never be given the same bank.
module frame_bank_sched #(
    parameter int FRAME_WORDS = 786432,
    parameter int ADDR_W      = 24,
    parameter int CNT_W       = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              wr_frame_start,
    input  logic              wr_frame_done,
    input  logic              video_vs,
    input  logic              freeze,
    output logic [1:0]        wr_bank,
    output logic [1:0]        rd_bank,
    output logic [ADDR_W-1:0] wr_base,
    output logic [ADDR_W-1:0] rd_base,
    output logic              rd_valid,
    output logic              rd_swap,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  repeat_cnt,
    output logic [CNT_W-1:0]  abort_cnt
);

    localparam logic [ADDR_W-1:0] BASE_0 = '0;
    localparam logic [ADDR_W-1:0] BASE_1 = ADDR_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] BASE_2 = ADDR_W'(2 * FRAME_WORDS);

    // Bank registers and flags
    logic [1:0]        w_q, w_d;
    logic [1:0]        r_q, r_d;
    logic [1:0]        s_q, s_d;
    logic              ready_q, ready_d;
    logic              wr_active_q, wr_active_d;
    logic              vs_q;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_swap_q, rd_swap_d;
    logic [ADDR_W-1:0] wr_base_q, wr_base_d;
    logic [ADDR_W-1:0] rd_base_q, rd_base_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  repeat_q, repeat_d;
    logic [CNT_W-1:0]  abort_q, abort_d;

    logic vs_rise;
    logic done_ok;

    // Base addresses come from a constant mux; banks only ever take values 0..2.
    function automatic logic [ADDR_W-1:0] bank_base(input logic [1:0] b);
        logic [ADDR_W-1:0] base;
        case (b)
            2'd0:    base = BASE_0;
            2'd1:    base = BASE_1;
            default: base = BASE_2;
        endcase
        return base;
    endfunction

    // Counters hold at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign vs_rise = video_vs & ~vs_q;
    assign done_ok = wr_frame_done & wr_active_q;

    // Next-state: writer done, then writer start, then reader vsync, in that order.
    always_comb begin
        w_d         = w_q;
        r_d         = r_q;
        s_d         = s_q;
        ready_d     = ready_q;
        wr_active_d = wr_active_q;
        rd_valid_d  = rd_valid_q;
        rd_swap_d   = 1'b0;
        drop_d      = drop_q;
        repeat_d    = repeat_q;
        abort_d     = abort_q;

        // A finished frame goes to the spare; an undisplayed spare is discarded.
        if (done_ok) begin
            w_d         = s_q;
            s_d         = w_q;
            ready_d     = 1'b1;
            wr_active_d = 1'b0;
            if (ready_q) begin
                drop_d = sat_inc(drop_q);
            end
        end

        // A start while a frame is still open restarts it in the same bank.
        // A done in the same cycle has already closed the previous frame.
        if (wr_frame_start) begin
            if (wr_active_d) begin
                abort_d = sat_inc(abort_q);
            end
            wr_active_d = 1'b1;
        end

        // Uses the post-writer spare, so a frame completing on this very
        // cycle goes straight to the display.
        if (vs_rise) begin
            if (ready_d && !freeze) begin
                r_d        = s_d;
                s_d        = r_q;
                ready_d    = 1'b0;
                rd_valid_d = 1'b1;
                rd_swap_d  = 1'b1;
            end else begin
                repeat_d = sat_inc(repeat_q);
            end
        end

        wr_base_d = bank_base(w_d);
        rd_base_d = bank_base(r_d);
    end

    // State and registered outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            w_q         <= 2'd0;
            r_q         <= 2'd1;
            s_q         <= 2'd2;
            ready_q     <= 1'b0;
            wr_active_q <= 1'b0;
            vs_q        <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_swap_q   <= 1'b0;
            wr_base_q   <= BASE_0;
            rd_base_q   <= BASE_1;
            drop_q      <= '0;
            repeat_q    <= '0;
            abort_q     <= '0;
        end else begin
            w_q         <= w_d;
            r_q         <= r_d;
            s_q         <= s_d;
            ready_q     <= ready_d;
            wr_active_q <= wr_active_d;
            vs_q        <= video_vs;
            rd_valid_q  <= rd_valid_d;
            rd_swap_q   <= rd_swap_d;
            wr_base_q   <= wr_base_d;
            rd_base_q   <= rd_base_d;
            drop_q      <= drop_d;
            repeat_q    <= repeat_d;
            abort_q     <= abort_d;
        end
    end

    assign wr_bank    = w_q;
    assign rd_bank    = r_q;
    assign wr_base    = wr_base_q;
    assign rd_base    = rd_base_q;
    assign rd_valid   = rd_valid_q;
    assign rd_swap    = rd_swap_q;
    assign drop_cnt   = drop_q;
    assign repeat_cnt = repeat_q;
    assign abort_cnt  = abort_q;

endmodule

// File: tb/tb_frame_bank_sched.sv
// Directed bench for frame_bank_sched with a reference model feeding a scoreboard.
module tb_frame_bank_sched;

    localparam int FW     = 100;
    localparam int ADDR_W = 9;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              sys_clk;
    logic              sys_rst;
    logic              wr_frame_start;
    logic              wr_frame_done;
    logic              video_vs;
    logic              freeze;
    logic [1:0]        wr_bank;
    logic [1:0]        rd_bank;
    logic [ADDR_W-1:0] wr_base;
    logic [ADDR_W-1:0] rd_base;
    logic              rd_valid;
    logic              rd_swap;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  repeat_cnt;
    logic [CNT_W-1:0]  abort_cnt;

    frame_bank_sched #(
        .FRAME_WORDS(FW),
        .ADDR_W     (ADDR_W),
        .CNT_W      (CNT_W)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .wr_frame_start(wr_frame_start),
        .wr_frame_done (wr_frame_done),
        .video_vs      (video_vs),
        .freeze        (freeze),
        .wr_bank       (wr_bank),
        .rd_bank       (rd_bank),
        .wr_base       (wr_base),
        .rd_base       (rd_base),
        .rd_valid      (rd_valid),
        .rd_swap       (rd_swap),
        .drop_cnt      (drop_cnt),
        .repeat_cnt    (repeat_cnt),
        .abort_cnt     (abort_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int w;
        int r;
        int valid;
        int swap;
        int drop;
        int rep;
        int abort;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int m_w, m_r, m_s, m_ready, m_act, m_vs, m_valid, m_drop, m_rep, m_abort;

    int third_bank;
    int newest_bank;

    task automatic chk(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_w = 0; m_r = 1; m_s = 2;
        m_ready = 0; m_act = 0; m_vs = 0; m_valid = 0;
        m_drop = 0; m_rep = 0; m_abort = 0;
        exp_q.delete();
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_bank"}, int'(wr_bank), 0);
        chk({tag, "_rd_bank"}, int'(rd_bank), 1);
        chk({tag, "_wr_base"}, int'(wr_base), 0);
        chk({tag, "_rd_base"}, int'(rd_base), FW);
        chk({tag, "_rd_valid"}, int'(rd_valid), 0);
        chk({tag, "_rd_swap"}, int'(rd_swap), 0);
        chk({tag, "_drop"}, int'(drop_cnt), 0);
        chk({tag, "_repeat"}, int'(repeat_cnt), 0);
        chk({tag, "_abort"}, int'(abort_cnt), 0);
    endtask

    // One clock of stimulus; caller is positioned 1 time unit after a rising edge.
    task automatic step(input bit st, input bit dn, input bit vs, input bit fz);
        exp_t e;
        int   tmp;
        bit   rise;
        bit   sw;
        wr_frame_start = st;
        wr_frame_done  = dn;
        video_vs       = vs;
        freeze         = fz;

        rise = vs && (m_vs == 0);
        m_vs = vs ? 1 : 0;
        sw   = 1'b0;
        if (dn && m_act == 1) begin
            tmp = m_w; m_w = m_s; m_s = tmp;
            if (m_ready == 1) m_drop = sat(m_drop);
            m_ready = 1;
            m_act   = 0;
        end
        if (st) begin
            if (m_act == 1) m_abort = sat(m_abort);
            m_act = 1;
        end
        if (rise) begin
            if (m_ready == 1 && !fz) begin
                tmp = m_r; m_r = m_s; m_s = tmp;
                m_ready = 0;
                m_valid = 1;
                sw      = 1'b1;
            end else begin
                m_rep = sat(m_rep);
            end
        end
        e.w = m_w; e.r = m_r; e.valid = m_valid; e.swap = sw ? 1 : 0;
        e.drop = m_drop; e.rep = m_rep; e.abort = m_abort;
        exp_q.push_back(e);

        @(posedge sys_clk);
        #1;
        wr_frame_start = 1'b0;
        wr_frame_done  = 1'b0;

        n_checks++;
        assert (exp_q.size() > 0) else begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%0d expected=1", exp_q.size());
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_bank", int'(wr_bank), e.w);
            chk("rd_bank", int'(rd_bank), e.r);
            chk("wr_base", int'(wr_base), e.w * FW);
            chk("rd_base", int'(rd_base), e.r * FW);
            chk("rd_valid", int'(rd_valid), e.valid);
            chk("rd_swap", int'(rd_swap), e.swap);
            chk("drop_cnt", int'(drop_cnt), e.drop);
            chk("repeat_cnt", int'(repeat_cnt), e.rep);
            chk("abort_cnt", int'(abort_cnt), e.abort);
        end
        n_checks++;
        assert (wr_bank != rd_bank && wr_bank != 2'd3 && rd_bank != 2'd3) else begin
            n_err++;
            $error("FAIL bank_distinct observed=w%0d_r%0d expected=distinct_0to2", wr_bank, rd_bank);
        end
    endtask

    task automatic vsync(input bit fz);
        step(0, 0, 1, fz);
        step(0, 0, 0, fz);
    endtask

    task automatic frame(input bit fz);
        step(1, 0, 0, fz);
        step(0, 1, 0, fz);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        #3;
        model_reset();
        check_reset_outputs("rst");
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        sys_rst        = 1'b1;
        wr_frame_start = 1'b0;
        wr_frame_done  = 1'b0;
        video_vs       = 1'b0;
        freeze         = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("init");
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;

        // Reset then first frame
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        chk("first_rd_bank", int'(rd_bank), 0);
        chk("first_wr_bank", int'(wr_bank), 2);
        chk("first_rd_valid", int'(rd_valid), 1);
        chk("first_rd_swap_hi", int'(rd_swap), 1);
        step(0, 0, 0, 0);
        chk("first_rd_swap_lo", int'(rd_swap), 0);

        // Writer faster than reader
        frame(0);
        frame(0);
        step(1, 0, 0, 0);
        third_bank = int'(wr_bank);
        step(0, 1, 0, 0);
        vsync(0);
        chk("fast_wr_drop", int'(drop_cnt), 2);
        chk("fast_wr_rd_bank", int'(rd_bank), third_bank);

        // Reader faster than writer, then freeze
        do_reset();
        frame(0);
        vsync(0);
        vsync(0);
        vsync(0);
        vsync(0);
        chk("fast_rd_repeat", int'(repeat_cnt), 3);
        chk("fast_rd_rd_bank", int'(rd_bank), 0);

        frame(1);
        vsync(1);
        frame(1);
        newest_bank = 1;
        vsync(1);
        chk("freeze_rd_bank", int'(rd_bank), 0);
        chk("freeze_repeat", int'(repeat_cnt), 5);
        chk("freeze_drop", int'(drop_cnt), 1);
        step(0, 0, 1, 0);
        chk("unfreeze_rd_bank", int'(rd_bank), newest_bank);
        chk("unfreeze_swap", int'(rd_swap), 1);
        step(0, 0, 0, 0);

        // Simultaneous done and vs_rise
        do_reset();
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        chk("simul_wr_bank", int'(wr_bank), 2);
        chk("simul_rd_bank", int'(rd_bank), 0);
        chk("simul_drop", int'(drop_cnt), 0);
        step(0, 0, 0, 0);
        vsync(0);
        chk("simul_ready_clear_repeat", int'(repeat_cnt), 1);
        chk("simul_rd_bank_hold", int'(rd_bank), 0);

        // Abort, spurious done, start+done in one cycle
        do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("abort_cnt", int'(abort_cnt), 1);
        chk("abort_wr_bank", int'(wr_bank), 2);
        step(0, 1, 0, 0);
        chk("spurious_wr_bank", int'(wr_bank), 2);
        chk("spurious_drop", int'(drop_cnt), 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("startdone_abort", int'(abort_cnt), 1);
        chk("startdone_wr_bank", int'(wr_bank), 0);
        step(0, 1, 0, 0);
        chk("startdone_drop", int'(drop_cnt), 2);

        // Counter saturation
        do_reset();
        for (int i = 0; i < CMAX + 3; i++) begin
            vsync(1);
        end
        chk("repeat_saturate", int'(repeat_cnt), CMAX);

        // Reset mid-frame
        frame(0);
        step(1, 0, 0, 0);
        #2;
        sys_rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("midrst");
        #2;
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        step(0, 1, 0, 0);
        chk("midrst_done_ignored", int'(wr_bank), 0);
        frame(0);
        vsync(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
